// File: rtl/examp_every_capture.sv
// examp_every_capture
//
// Capture stage for the every-signal output block. The three asynchronous
// upstream outputs are brought into the clk domain through two-flop
// synchronizers. Any disagreement between them sets a sticky flag. The
// synchronized o is debounced into a clean level, and each debounced edge is
// offered as a single-entry event over a valid/ready handshake. Rising level
// flips are counted with saturation.
//
// Ports:
//   clk        in   sole clock, rising edge
//   rst        in   asynchronous active-high reset
//   o          in   asynchronous upstream signal (debounced)
//   tempa      in   asynchronous upstream signal (compared only)
//   tempb      in   asynchronous upstream signal (compared only)
//   clr        in   synchronous clear of mismatch and rise_count
//   evt_ready  in   consumer accepts the pending event
//   evt_valid  out  event pending
//   evt_rise   out  event polarity, 1 = rising, 0 = falling
//   evt_drop   out  one-cycle pulse when an event is lost to backpressure
//   level      out  debounced o
//   mismatch   out  sticky disagreement flag
//   rise_count out  saturating count of rising level flips
module examp_every_capture #(
    parameter int DEBOUNCE = 4,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             o,
    input  logic             tempa,
    input  logic             tempb,
    input  logic             clr,
    input  logic             evt_ready,
    output logic             evt_valid,
    output logic             evt_rise,
    output logic             evt_drop,
    output logic             level,
    output logic             mismatch,
    output logic [CNT_W-1:0] rise_count
);

    typedef enum logic {
        STABLE   = 1'b0,
        CHANGING = 1'b1
    } state_t;

    localparam logic [7:0]       DB_LAST = 8'(DEBOUNCE - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Two-flop synchronizers
    logic o_p0, a_p0, b_p0;
    logic s_o, s_a, s_b;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_p0 <= 1'b0;
            a_p0 <= 1'b0;
            b_p0 <= 1'b0;
            s_o  <= 1'b0;
            s_a  <= 1'b0;
            s_b  <= 1'b0;
        end else begin
            o_p0 <= o;
            a_p0 <= tempa;
            b_p0 <= tempb;
            s_o  <= o_p0;
            s_a  <= a_p0;
            s_b  <= b_p0;
        end
    end

    // Sticky mismatch; a fresh disagreement outranks clr
    logic disagree;
    assign disagree = (s_o != s_a) || (s_o != s_b);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mismatch <= 1'b0;
        end else if (disagree) begin
            mismatch <= 1'b1;
        end else if (clr) begin
            mismatch <= 1'b0;
        end
    end

    // Debounce FSM
    state_t     state, state_next;
    logic [7:0] cnt, cnt_next;
    logic       level_next;
    logic       new_evt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= STABLE;
            cnt   <= 8'd0;
            level <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            level <= level_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        level_next = level;
        new_evt    = 1'b0;
        case (state)
            STABLE: begin
                if (s_o != level) begin
                    // A single-cycle debounce accepts the change immediately
                    if (DEBOUNCE == 1) begin
                        level_next = s_o;
                        cnt_next   = 8'd0;
                        new_evt    = 1'b1;
                    end else begin
                        state_next = CHANGING;
                        cnt_next   = 8'd1;
                    end
                end
            end
            CHANGING: begin
                if (s_o == level) begin
                    state_next = STABLE;
                    cnt_next   = 8'd0;
                end else if (cnt == DB_LAST) begin
                    level_next = s_o;
                    state_next = STABLE;
                    cnt_next   = 8'd0;
                    new_evt    = 1'b1;
                end else begin
                    cnt_next = cnt + 8'd1;
                end
            end
            default: begin
                state_next = STABLE;
                cnt_next   = 8'd0;
            end
        endcase
    end

    // Single-entry event register; a held, unaccepted event is never replaced
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            evt_valid <= 1'b0;
            evt_rise  <= 1'b0;
            evt_drop  <= 1'b0;
        end else begin
            evt_drop <= 1'b0;
            if (new_evt) begin
                if (!evt_valid || evt_ready) begin
                    evt_valid <= 1'b1;
                    evt_rise  <= level_next;
                end else begin
                    evt_drop <= 1'b1;
                end
            end else if (evt_valid && evt_ready) begin
                evt_valid <= 1'b0;
            end
        end
    end

    // Rising flips are counted whether or not their event was delivered
    logic rise_flip;
    assign rise_flip = new_evt && level_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rise_count <= '0;
        end else if (clr) begin
            rise_count <= '0;
        end else if (rise_flip && (rise_count != CNT_MAX)) begin
            rise_count <= rise_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_examp_every_capture.sv
module tb_examp_every_capture;

    logic       clk = 1'b0;
    logic       rst;
    logic       o, tempa, tempb, clr, evt_ready;
    logic       evt_valid, evt_rise, evt_drop, level, mismatch;
    logic [7:0] rise_count;
    logic       evt_valid2, evt_rise2, evt_drop2, level2, mismatch2;
    logic [1:0] rise_count2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    examp_every_capture #(.DEBOUNCE(4), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .o(o), .tempa(tempa), .tempb(tempb),
        .clr(clr), .evt_ready(evt_ready), .evt_valid(evt_valid),
        .evt_rise(evt_rise), .evt_drop(evt_drop), .level(level),
        .mismatch(mismatch), .rise_count(rise_count)
    );

    examp_every_capture #(.DEBOUNCE(4), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .o(o), .tempa(tempa), .tempb(tempb),
        .clr(clr), .evt_ready(evt_ready), .evt_valid(evt_valid2),
        .evt_rise(evt_rise2), .evt_drop(evt_drop2), .level(level2),
        .mismatch(mismatch2), .rise_count(rise_count2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the last edge
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic v);
        o = v; tempa = v; tempb = v;
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0; evt_ready = 1'b1;
        set_in(1'b0);
        tick(3);
        check("reset_level", level, 0);
        check("reset_valid", evt_valid, 0);
        check("reset_count", rise_count, 0);
        check("reset_mismatch", mismatch, 0);
        rst = 1'b0;
        tick(2);

        // Reset in the middle of a debounce
        set_in(1'b1);
        tick(4);
        rst = 1'b1;
        #1;
        check("midrst_level", level, 0);
        check("midrst_valid", evt_valid, 0);
        check("midrst_drop", evt_drop, 0);
        check("midrst_count", rise_count, 0);
        tick(1);
        rst = 1'b0;
        tick(5);
        check("rel_level_e5", level, 0);
        tick(1);
        check("rel_level_e6", level, 1);
        check("rise_valid", evt_valid, 1);
        check("rise_pol", evt_rise, 1);
        check("rise_count1", rise_count, 1);
        tick(1);
        check("rise_valid_clr", evt_valid, 0);

        // Falling edge with handshake
        set_in(1'b0);
        tick(6);
        check("fall_level", level, 0);
        check("fall_valid", evt_valid, 1);
        check("fall_pol", evt_rise, 0);
        check("fall_count", rise_count, 1);
        tick(1);
        check("fall_valid_clr", evt_valid, 0);

        // Glitch rejection
        pulse_clr();
        check("clr_count", rise_count, 0);
        set_in(1'b1);
        tick(3);
        set_in(1'b0);
        tick(10);
        check("glitch_level", level, 0);
        check("glitch_valid", evt_valid, 0);
        check("glitch_count", rise_count, 0);
        check("glitch_mismatch", mismatch, 0);

        // Backpressure drop
        evt_ready = 1'b0;
        set_in(1'b1);
        tick(6);
        check("bp_rise_level", level, 1);
        check("bp_rise_valid", evt_valid, 1);
        check("bp_rise_pol", evt_rise, 1);
        set_in(1'b0);
        tick(5);
        check("bp_level_hold", level, 1);
        check("bp_drop_early", evt_drop, 0);
        tick(1);
        check("bp_fall_level", level, 0);
        check("bp_drop", evt_drop, 1);
        check("bp_valid_held", evt_valid, 1);
        check("bp_pol_held", evt_rise, 1);
        check("bp_count", rise_count, 1);
        tick(1);
        check("bp_drop_end", evt_drop, 0);
        check("bp_pol_held2", evt_rise, 1);
        evt_ready = 1'b1;
        tick(1);
        check("bp_valid_clr", evt_valid, 0);

        // Mismatch and clear
        tempa = 1'b1;
        tick(1);
        tempa = 1'b0;
        tick(1);
        check("mm_e2", mismatch, 0);
        tick(1);
        check("mm_e3", mismatch, 1);
        tick(3);
        check("mm_sticky", mismatch, 1);
        pulse_clr();
        check("mm_clr", mismatch, 0);
        tempa = 1'b1;
        tick(4);
        check("mm_persist", mismatch, 1);
        pulse_clr();
        check("mm_set_wins", mismatch, 1);
        tempa = 1'b0;
        tick(3);
        pulse_clr();
        check("mm_clr2", mismatch, 0);
        check("mm_no_level", level, 0);

        // Counter saturation on the narrow instance
        pulse_clr();
        for (int i = 0; i < 5; i++) begin
            set_in(1'b1);
            tick(6);
            set_in(1'b0);
            tick(6);
        end
        check("sat_count2", rise_count2, 3);
        check("sat_count8", rise_count, 5);
        set_in(1'b1);
        tick(5);
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        check("clrwin_level", level2, 1);
        check("clrwin_count2", rise_count2, 0);
        check("clrwin_count8", rise_count, 0);
        tick(1);
        check("clrwin_hold", rise_count2, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
